// File: rtl/data_memory_pipe.sv
// Pipelined RV32I data memory: byte/half/word loads and stores, fixed-latency in-order responses, fault flagging.
// Optional post-reset zeroing of the array is built when DMEM_INIT_CLEAR_EN is defined.
module data_memory_pipe #(
  parameter int          DEPTH_WORDS  = 256,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      offset;
  logic [IDX_W-1:0] wordIdx;
  logic             accept;
  logic             reqErr;
  logic [3:0]       byteEn;
  logic [31:0]      laneData;
  logic [31:0]      rdWord;
  logic [7:0]       rdByte;
  logic [15:0]      rdHalf;
  logic [31:0]      loadData;
  logic             initBusy;

  logic [READ_LATENCY-1:0] pipeValid;
  logic [READ_LATENCY-1:0] pipeErr;
  logic [31:0]             pipeData [READ_LATENCY];

  // Unsigned subtraction makes addresses below the base wrap to huge offsets, so one compare covers both ends.
  assign offset  = req_addr - BASE_ADDR;
  assign wordIdx = offset[IDX_W+1:2];
  assign accept  = req_valid && req_ready && !rst;

  always_comb begin
    reqErr = (offset >= SPAN);
    case (req_size)
      2'b00:   ;
      2'b01:   if (req_addr[0]) reqErr = 1'b1;
      2'b10:   if (req_addr[1:0] != 2'b00) reqErr = 1'b1;
      default: reqErr = 1'b1;
    endcase
  end

  always_comb begin
    byteEn   = 4'b0000;
    laneData = req_wdata;
    case (req_size)
      2'b00: begin
        byteEn   = 4'b0001 << req_addr[1:0];
        laneData = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byteEn   = req_addr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{req_wdata[15:0]}};
      end
      2'b10:   byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  // Load lanes are extracted and extended here so the pipeline only carries final response data.
  always_comb begin
    rdWord = mem[wordIdx];
    case (req_addr[1:0])
      2'b00:   rdByte = rdWord[7:0];
      2'b01:   rdByte = rdWord[15:8];
      2'b10:   rdByte = rdWord[23:16];
      default: rdByte = rdWord[31:24];
    endcase
    rdHalf   = req_addr[1] ? rdWord[31:16] : rdWord[15:0];
    loadData = '0;
    if (accept && !req_write && !reqErr) begin
      case (req_size)
        2'b00:   loadData = {{24{req_sign & rdByte[7]}}, rdByte};
        2'b01:   loadData = {{16{req_sign & rdHalf[15]}}, rdHalf};
        2'b10:   loadData = rdWord;
        default: loadData = '0;
      endcase
    end
  end

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  state_t           stateNext;
  logic [IDX_W-1:0] clr_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == INIT && clr_idx == IDX_W'(DEPTH_WORDS - 1)) stateNext = RUN;
  end

  always_comb begin
    req_ready = (state == RUN);
    initBusy  = (state == INIT);
  end

  always_ff @(posedge clk) begin
    if (rst)                clr_idx <= '0;
    else if (state == INIT) clr_idx <= clr_idx + 1'b1;
  end

  // The clear sweep and stores never coincide because req_ready is low throughout INIT.
  always_ff @(posedge clk) begin
    if (!rst && state == INIT) begin
      mem[clr_idx] <= '0;
    end else if (accept && req_write && !reqErr) begin
      for (int i = 0; i < 4; i++)
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
    end
  end
`else
  assign req_ready = 1'b1;
  assign initBusy  = 1'b0;

  always_ff @(posedge clk) begin
    if (accept && req_write && !reqErr) begin
      for (int i = 0; i < 4; i++)
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
    end
  end
`endif

  // Stage 0 captures at the acceptance edge; the last stage is the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipeValid <= '0;
      pipeErr   <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipeData[k] <= '0;
    end else begin
      pipeValid[0] <= accept;
      pipeErr[0]   <= accept && reqErr;
      pipeData[0]  <= loadData;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipeValid[k] <= pipeValid[k-1];
        pipeErr[k]   <= pipeErr[k-1];
        pipeData[k]  <= pipeData[k-1];
      end
    end
  end

  assign rsp_valid = pipeValid[READ_LATENCY-1];
  assign rsp_err   = pipeErr[READ_LATENCY-1];
  assign rsp_rdata = pipeData[READ_LATENCY-1];
  assign busy      = initBusy || (|pipeValid);

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed self-checking bench for data_memory_pipe (32 words, latency 3).
// Also follows the clear-after-reset behaviour when built with DMEM_INIT_CLEAR_EN.
module tb_data_memory_pipe;

  localparam int DEPTH = 32;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  data_memory_pipe #(
    .DEPTH_WORDS (DEPTH),
    .READ_LATENCY(LAT),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size (req_size),
    .req_sign (req_sign),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic setReq(input logic w, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_write = w;
    req_size  = size;
    req_sign  = sgn;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  // Presents one request, waits for its acceptance edge, and leaves time at 1 ns after that edge.
  task automatic applyStimulus(input logic w, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wd);
    setReq(w, size, sgn, addr, wd);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic expectResponse(input string tag, input logic [31:0] expData, input logic expErr);
    int n = 1;
    while (rsp_valid !== 1'b1 && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, " latency"}, 32'(n), 32'(LAT));
    checkOutput({tag, " data"}, rsp_rdata, expData);
    checkOutput({tag, " err"}, {31'b0, rsp_err}, {31'b0, expErr});
    @(posedge clk);
    #1;
  endtask

  task automatic doAccess(input string tag, input logic w, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] expData, input logic expErr);
    applyStimulus(w, size, sgn, addr, wd);
    expectResponse(tag, expData, expErr);
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, " ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen;
    int lowCycles;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset rsp_err", {31'b0, rsp_err}, 32'd0);
`ifdef DMEM_INIT_CLEAR_EN
    checkOutput("reset busy", {31'b0, busy}, 32'd1);
    lowCycles = 0;
    while (req_ready !== 1'b1 && lowCycles < 200) begin
      lowCycles++;
      @(posedge clk);
      #1;
    end
    checkOutput("init ready-low cycles", 32'(lowCycles), 32'(DEPTH));
    doAccess("clear LW top", 1'b0, 2'b10, 1'b0, 32'(DEPTH * 4 - 4), '0, 32'h0, 1'b0);
`else
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset ready", {31'b0, req_ready}, 32'd1);
`endif

    doAccess("SW 0x10",  1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
    doAccess("SB 0x12",  1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, 32'h0, 1'b0);
    doAccess("LW 0x10",  1'b0, 2'b10, 1'b0, 32'h10, '0, 32'h11AA_3344, 1'b0);
    doAccess("LB 0x12",  1'b0, 2'b00, 1'b1, 32'h12, '0, 32'hFFFF_FFAA, 1'b0);
    doAccess("LBU 0x12", 1'b0, 2'b00, 1'b0, 32'h12, '0, 32'h0000_00AA, 1'b0);
    doAccess("LHU 0x12", 1'b0, 2'b01, 1'b0, 32'h12, '0, 32'h0000_11AA, 1'b0);
    doAccess("LB 0x11",  1'b0, 2'b00, 1'b1, 32'h11, '0, 32'h0000_0033, 1'b0);
    doAccess("LH 0x10",  1'b0, 2'b01, 1'b1, 32'h10, '0, 32'h0000_3344, 1'b0);
    doAccess("SW 0x14",  1'b1, 2'b10, 1'b0, 32'h14, 32'h5566_7788, 32'h0, 1'b0);
    doAccess("SH 0x16",  1'b1, 2'b01, 1'b0, 32'h16, 32'hBEEF_8001, 32'h0, 1'b0);
    doAccess("LW 0x14",  1'b0, 2'b10, 1'b0, 32'h14, '0, 32'h8001_7788, 1'b0);
    doAccess("LH 0x16",  1'b0, 2'b01, 1'b1, 32'h16, '0, 32'hFFFF_8001, 1'b0);

    doAccess("SW 0x0", 1'b1, 2'b10, 1'b0, 32'h0, 32'd1, 32'h0, 1'b0);
    doAccess("SW 0x4", 1'b1, 2'b10, 1'b0, 32'h4, 32'd2, 32'h0, 1'b0);
    doAccess("SW 0x8", 1'b1, 2'b10, 1'b0, 32'h8, 32'd3, 32'h0, 1'b0);

    setReq(1'b0, 2'b10, 1'b0, 32'h0, '0);
    @(posedge clk); #1;
    checkOutput("b2b busy e1", {31'b0, busy}, 32'd1);
    checkOutput("b2b valid e1", {31'b0, rsp_valid}, 32'd0);
    req_addr = 32'h4;
    @(posedge clk); #1;
    checkOutput("b2b valid e2", {31'b0, rsp_valid}, 32'd0);
    req_addr = 32'h8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("b2b valid e3", {31'b0, rsp_valid}, 32'd1);
    checkOutput("b2b data e3", rsp_rdata, 32'd1);
    @(posedge clk); #1;
    checkOutput("b2b valid e4", {31'b0, rsp_valid}, 32'd1);
    checkOutput("b2b data e4", rsp_rdata, 32'd2);
    @(posedge clk); #1;
    checkOutput("b2b valid e5", {31'b0, rsp_valid}, 32'd1);
    checkOutput("b2b data e5", rsp_rdata, 32'd3);
    @(posedge clk); #1;
    checkOutput("b2b valid e6", {31'b0, rsp_valid}, 32'd0);
    checkOutput("b2b busy e6", {31'b0, busy}, 32'd0);

    setReq(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    setReq(1'b0, 2'b10, 1'b0, 32'h40, '0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("raw valid e2", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("raw store valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("raw store data", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    checkOutput("raw load valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("raw load data", rsp_rdata, 32'hDEAD_BEEF);
    checkOutput("raw load err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk); #1;

    doAccess("fault LH 0x21",    1'b0, 2'b01, 1'b0, 32'h21, '0, 32'h0, 1'b1);
    doAccess("fault LW 0x22",    1'b0, 2'b10, 1'b0, 32'h22, '0, 32'h0, 1'b1);
    doAccess("fault size11 st",  1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1);
    doAccess("fault size11 ld",  1'b0, 2'b11, 1'b0, 32'h10, '0, 32'h0, 1'b1);
    doAccess("fault SW range",   1'b1, 2'b10, 1'b0, 32'(DEPTH * 4), 32'h1234_5678, 32'h0, 1'b1);
    doAccess("fault LW below",   1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, '0, 32'h0, 1'b1);
    doAccess("after fault LW 0", 1'b0, 2'b10, 1'b0, 32'h0, '0, 32'd1, 1'b0);
    doAccess("after fault 0x10", 1'b0, 2'b10, 1'b0, 32'h10, '0, 32'h11AA_3344, 1'b0);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h4, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      if (rsp_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checkOutput("flush no response", 32'(seen), 32'd0);
`ifdef DMEM_INIT_CLEAR_EN
    waitReady("flush");
    doAccess("flush LW 0x4 cleared", 1'b0, 2'b10, 1'b0, 32'h4, '0, 32'h0, 1'b0);
`else
    checkOutput("flush busy", {31'b0, busy}, 32'd0);
    doAccess("flush LW 0x4 kept", 1'b0, 2'b10, 1'b0, 32'h4, '0, 32'd2, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
